// File: rtl/dac_apb_sequencer.sv
// APB master streaming 12-bit DAC samples from a small FIFO, one write per sample-rate tick.
// Latency: tick -> SETUP in 2 cycles; sample_ready deasserts only when the FIFO is full.
module dac_apb_sequencer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] DAC_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT  = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [15:0]               divider,
    input  logic                      clr_err,
    input  logic [11:0]               sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [31:0]               PADDR,
    output logic [31:0]               PWDATA,
    output logic [3:0]                PSTRB,
    input  logic                      PREADY,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      busy,
    output logic                      underrun,
    output logic                      missed_tick,
    output logic                      timeout_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t        state_q;
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   count_q, count_d;
    logic          pending_q, pending_d;
    logic [7:0]    wait_q;
    logic          psel_q, penable_q, pwrite_q;
    logic [31:0]   paddr_q, pwdata_q;
    logic [3:0]    pstrb_q;
    logic          underrun_q, missed_q, timeout_q;

    logic push, pop, fifo_empty, tick, start, wait_last;
    logic underrun_set, missed_set, timeout_set;

    // DEPTH is a power of two, so level < DEPTH exactly when the MSB is clear.
    assign sample_ready = ~level_q[AW];
    assign fifo_empty   = (level_q == '0);
    assign push         = sample_valid & sample_ready;
    assign wait_last    = (wait_q == 8'(TIMEOUT - 1));
    assign pop          = (state_q == S_ACCESS) & (PREADY | wait_last);
    assign tick         = enable & (count_q >= divider);
    assign start        = (state_q == S_IDLE) & pending_q & ~fifo_empty & enable;

    assign underrun_set = tick & fifo_empty;
    assign missed_set   = tick & ~fifo_empty & pending_q;
    assign timeout_set  = (state_q == S_ACCESS) & wait_last & ~PREADY;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;

        count_d = count_q + 16'd1;
        if (!enable || tick)
            count_d = '0;

        pending_d = pending_q;
        if (!enable)
            pending_d = 1'b0;
        else if (tick && !fifo_empty)
            pending_d = 1'b1;
        else if (start)
            pending_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= sample_in;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            underrun_q  <= 1'b0;
            missed_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q     <= level_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            // A set in the same cycle as clr_err takes priority.
            underrun_q  <= underrun_set | (underrun_q & ~clr_err);
            missed_q    <= missed_set   | (missed_q   & ~clr_err);
            timeout_q   <= timeout_set  | (timeout_q  & ~clr_err);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            wait_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_SETUP;
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= DAC_ADDR;
                        pwdata_q <= {20'b0, mem_q[rd_ptr_q]};
                        pstrb_q  <= 4'b0011;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                end
                S_ACCESS: begin
                    if (PREADY || wait_last) begin
                        state_q   <= S_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign fifo_level  = level_q;
    assign busy        = (state_q != S_IDLE);
    assign underrun    = underrun_q;
    assign missed_tick = missed_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_dac_apb_sequencer.sv
// Directed bench for dac_apb_sequencer with a delayed-PREADY DAC slave model.
module tb_dac_apb_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] divider = '0;
    logic        clr_err = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  fifo_level;
    logic        busy, underrun, missed_tick, timeout_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Slave model: PREADY rises on the slave_delay-th ACCESS cycle.
    bit slave_en = 1'b0;
    int slave_delay = 13;
    int acc_cnt = 0;
    logic [31:0] mon_q[$];

    dac_apb_sequencer dut (
        .CLK(CLK), .RST(RST), .enable(enable), .divider(divider), .clr_err(clr_err),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PREADY(PREADY), .fifo_level(fifo_level), .busy(busy),
        .underrun(underrun), .missed_tick(missed_tick), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    always @(posedge CLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign PREADY = slave_en && PSEL && PENABLE && (acc_cnt == slave_delay - 1);

    always @(negedge CLK) if (PSEL && !PENABLE) mon_q.push_back(PWDATA);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [11:0] d);
        sample_in = d;
        sample_valid = 1'b1;
        chk("push_ready", {31'b0, sample_ready}, 32'd1);
        step(1);
        sample_valid = 1'b0;
    endtask

    task automatic wait_setup(input string tag, output int t);
        int n = 0;
        while (!(PSEL && !PENABLE) && n < 200) begin
            step(1);
            n++;
        end
        chk({tag, "_seen"}, {31'b0, (PSEL && !PENABLE)}, 32'd1);
        t = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            step(1);
            n++;
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, {29'b0, underrun, missed_tick, timeout_err}, {29'b0, exp});
    endtask

    initial begin
        int t0, t1, t2, n;
        logic seen;
        logic [11:0] s2 [3];
        s2[0] = 12'h123; s2[1] = 12'hABC; s2[2] = 12'hFFF;

        // Reset state
        step(2);
        chk("rst_psel", {31'b0, PSEL}, 32'd0);
        chk("rst_level", {29'b0, fifo_level}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk_flags("rst_flags", 3'b000);
        RST = 1'b1;
        step(1);
        chk("rst_ready", {31'b0, sample_ready}, 32'd1);

        // Test 1: asynchronous reset in the middle of ACCESS
        push(12'h0A5);
        divider = 16'd0;
        enable = 1'b1;
        wait_setup("t1", t0);
        step(2);
        chk("t1_in_access", {30'b0, PSEL, PENABLE}, 32'd3);
        #2 RST = 1'b0;
        #1;
        chk("t1_psel", {31'b0, PSEL}, 32'd0);
        chk("t1_penable", {31'b0, PENABLE}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        chk("t1_level", {29'b0, fifo_level}, 32'd0);
        chk_flags("t1_flags", 3'b000);
        enable = 1'b0;
        step(1);
        RST = 1'b1;
        step(1);
        chk("t1_ready", {31'b0, sample_ready}, 32'd1);

        // Test 2: three writes, 13-cycle slave, tick every 20 cycles
        slave_en = 1'b1;
        slave_delay = 13;
        divider = 16'd19;
        for (int i = 0; i < 3; i++) push(s2[i]);
        chk("t2_level", {29'b0, fifo_level}, 32'd3);
        enable = 1'b1;
        t1 = 0;
        for (int i = 0; i < 3; i++) begin
            wait_setup("t2", t2);
            chk("t2_pwdata", PWDATA, {20'b0, s2[i]});
            chk("t2_pstrb", {28'b0, PSTRB}, 32'h3);
            chk("t2_pwrite", {31'b0, PWRITE}, 32'd1);
            chk("t2_paddr", PADDR, 32'h0);
            if (i > 0) chk("t2_spacing", t2 - t1, 32'd20);
            t1 = t2;
            step(1);
        end
        wait_idle("t2");
        enable = 1'b0;
        step(1);
        chk_flags("t2_flags", 3'b000);
        chk("t2_level_end", {29'b0, fifo_level}, 32'd0);
        chk("t2_pwdata_idle", PWDATA, 32'd0);

        // Test 3: ticks faster than transfers -> missed_tick, order preserved
        divider = 16'd4;
        for (int i = 0; i < 3; i++) push(12'h300 + 12'(i));
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_setup("t3", t2);
            chk("t3_pwdata", PWDATA, 32'h300 + i);
            step(1);
        end
        wait_idle("t3");
        enable = 1'b0;
        step(1);
        chk("t3_missed", {31'b0, missed_tick}, 32'd1);
        chk("t3_level_end", {29'b0, fifo_level}, 32'd0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk_flags("t3_cleared", 3'b000);

        // Test 4: ticks with empty FIFO -> underrun, no transfers
        divider = 16'd7;
        enable = 1'b1;
        seen = 1'b0;
        step(7);
        chk("t4_before_tick", {31'b0, underrun}, 32'd0);
        step(1);
        chk("t4_underrun", {31'b0, underrun}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            seen = seen | PSEL;
            step(1);
        end
        chk("t4_no_psel", {31'b0, seen}, 32'd0);
        chk("t4_missed", {31'b0, missed_tick}, 32'd0);
        enable = 1'b0;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("t4_clr", {31'b0, underrun}, 32'd0);

        // Test 5: PREADY stuck low -> 32-cycle ACCESS then abort
        slave_en = 1'b0;
        divider = 16'd3;
        push(12'h5A5);
        chk("t5_level1", {29'b0, fifo_level}, 32'd1);
        enable = 1'b1;
        wait_setup("t5", t0);
        step(1);
        n = 0;
        while (PSEL && PENABLE && n < 100) begin
            if (n == 0) chk("t5_level_in_access", {29'b0, fifo_level}, 32'd1);
            n++;
            step(1);
        end
        chk("t5_access_len", n, 32'd32);
        chk("t5_idle_next", {31'b0, busy}, 32'd0);
        chk("t5_timeout", {31'b0, timeout_err}, 32'd1);
        chk("t5_level0", {29'b0, fifo_level}, 32'd0);
        enable = 1'b0;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk_flags("t5_clr", 3'b000);

        // Test 6: fill to DEPTH, refuse 5th, then push and pop together
        slave_en = 1'b1;
        slave_delay = 1;
        divider = 16'd0;
        mon_q.delete();
        for (int i = 1; i <= 4; i++) push(12'(i * 12'h111));
        chk("t6_full_level", {29'b0, fifo_level}, 32'd4);
        chk("t6_full_ready", {31'b0, sample_ready}, 32'd0);
        sample_in = 12'h555;
        sample_valid = 1'b1;
        step(2);
        chk("t6_no_accept", {29'b0, fifo_level}, 32'd4);
        sample_valid = 1'b0;
        enable = 1'b1;
        n = 0;
        while (fifo_level != 3'd3 && n < 100) begin step(1); n++; end
        chk("t6_first_pop", {29'b0, fifo_level}, 32'd3);
        n = 0;
        while (!(PSEL && PENABLE) && n < 100) begin step(1); n++; end
        chk("t6_access_pready", {30'b0, PENABLE, PREADY}, 32'd3);
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        chk("t6_push_pop_level", {29'b0, fifo_level}, 32'd3);
        n = 0;
        while ((fifo_level != 3'd0 || busy) && n < 200) begin step(1); n++; end
        enable = 1'b0;
        chk("t6_drained", {29'b0, fifo_level}, 32'd0);
        chk("t6_count", mon_q.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("t6_order", (i < mon_q.size()) ? mon_q[i] : 32'hDEAD, 32'(i + 1) * 32'h111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
